aes_core_sched: RTL and testbench

Scheduler that shares a single AES core between two requesters, each holding its own 256-bit key. Each requester issues key-load, encrypt and decrypt commands; the scheduler arbitrates round-robin, reloads the core key schedule only when ownership changes, then sequences the core and returns the result. It sits between the bus-side requesters and the AES datapath, replacing the direct create-key/encrypt/decrypt calls made into the core.

---
 rtl/aes_core_sched.sv | 208 ++++++++++++++++++++
 tb/tb_aes_core_sched.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_core_sched.sv
// -----------------------------------------------------------------------------
// aes_core_sched
// Shares one AES core between two requesters, each of which keeps its own
// 256-bit key. Commands (KEY / ENC / DEC) are arbitrated round-robin. The core
// key schedule is re-expanded only when the requester that owns the core
// changes, or when the owner has replaced its key since the last expansion.
// Only one command is in flight at a time.
//
// Ports
//   clk, resetL        : clock (rising edge), asynchronous active-low reset
//   req_valid/ready    : per-requester handshake, bit i = requester i
//   req_op             : 2-bit op per requester (00 KEY, 01 ENC, 10 DEC, 11 rsvd)
//   req_key/req_data   : per-requester key and data block
//   resp_valid         : one-cycle completion pulse, bit i = requester i
//   resp_err/resp_data : result qualifiers, valid with resp_valid
//   core_key_load/core_key/core_key_ready : key expansion handshake with core
//   core_start/core_decrypt/core_din      : block operation launch
//   core_done/core_dout                   : block operation completion
// -----------------------------------------------------------------------------
module aes_core_sched #(
  parameter int KEY_W  = 256,
  parameter int DATA_W = 128
) (
  input  logic                  clk,
  input  logic                  resetL,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [3:0]            req_op,
  input  logic [2*KEY_W-1:0]    req_key,
  input  logic [2*DATA_W-1:0]   req_data,
  output logic [1:0]            resp_valid,
  output logic                  resp_err,
  output logic [DATA_W-1:0]     resp_data,
  output logic                  core_key_load,
  output logic [KEY_W-1:0]      core_key,
  input  logic                  core_key_ready,
  output logic                  core_start,
  output logic                  core_decrypt,
  output logic [DATA_W-1:0]     core_din,
  input  logic                  core_done,
  input  logic [DATA_W-1:0]     core_dout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KLOAD,
    S_KWAIT,
    S_START,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [1:0] OP_KEY = 2'b00;
  localparam logic [1:0] OP_DEC = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  state_t              state_q, state_d;
  logic                id_q, id_d;
  logic [1:0]          op_q, op_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                err_q, err_d;
  logic [KEY_W-1:0]    key_q [2];
  logic [KEY_W-1:0]    key_d [2];
  logic [1:0]          key_vld_q, key_vld_d;
  logic                owner_q, owner_d;
  logic                owner_vld_q, owner_vld_d;
  logic                rr_ptr_q, rr_ptr_d;

  // Arbitration: a lone requester wins outright; on a tie rr_ptr decides.
  logic                win;
  logic [1:0]          win_op;
  logic [KEY_W-1:0]    win_key;
  logic [DATA_W-1:0]   win_data;

  assign win      = (&req_valid) ? rr_ptr_q : req_valid[1];
  assign win_op   = win ? req_op[3:2] : req_op[1:0];
  assign win_key  = win ? req_key[2*KEY_W-1:KEY_W] : req_key[KEY_W-1:0];
  assign win_data = win ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];

  always_comb begin
    state_d       = state_q;
    id_d          = id_q;
    op_d          = op_q;
    data_d        = data_q;
    res_d         = res_q;
    err_d         = err_q;
    key_d[0]      = key_q[0];
    key_d[1]      = key_q[1];
    key_vld_d     = key_vld_q;
    owner_d       = owner_q;
    owner_vld_d   = owner_vld_q;
    rr_ptr_d      = rr_ptr_q;

    req_ready     = 2'b00;
    resp_valid    = 2'b00;
    resp_err      = 1'b0;
    resp_data     = '0;
    core_key_load = 1'b0;
    core_key      = '0;
    core_start    = 1'b0;
    core_decrypt  = 1'b0;
    core_din      = '0;

    unique case (state_q)
      S_IDLE: begin
        // resetL gating keeps ready low while reset is held, even though the
        // state register already reads IDLE.
        if (resetL && (|req_valid)) begin
          req_ready = win ? 2'b10 : 2'b01;
          id_d      = win;
          op_d      = win_op;
          data_d    = win_data;
          res_d     = '0;
          err_d     = 1'b0;
          if (win_op == OP_KEY) begin
            key_d[win]     = win_key;
            key_vld_d[win] = 1'b1;
            // The core still holds the old expansion for this requester.
            if (owner_vld_q && (owner_q == win)) begin
              owner_vld_d = 1'b0;
            end
            state_d = S_RESP;
          end else if ((win_op == OP_RSV) || !key_vld_q[win]) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else if (owner_vld_q && (owner_q == win)) begin
            state_d = S_START;
          end else begin
            state_d = S_KLOAD;
          end
        end
      end

      S_KLOAD: begin
        core_key_load = 1'b1;
        core_key      = key_q[id_q];
        state_d       = S_KWAIT;
      end

      S_KWAIT: begin
        core_key = key_q[id_q];
        if (core_key_ready) begin
          owner_d     = id_q;
          owner_vld_d = 1'b1;
          state_d     = S_START;
        end
      end

      S_START: begin
        core_start   = 1'b1;
        core_decrypt = (op_q == OP_DEC);
        core_din     = data_q;
        state_d      = S_WAIT;
      end

      S_WAIT: begin
        if (core_done) begin
          res_d   = core_dout;
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        resp_valid = id_q ? 2'b10 : 2'b01;
        resp_err   = err_q;
        resp_data  = res_q;
        rr_ptr_d   = ~id_q;
        state_d    = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetL) begin
    if (!resetL) begin
      state_q     <= S_IDLE;
      id_q        <= 1'b0;
      op_q        <= 2'b00;
      data_q      <= '0;
      res_q       <= '0;
      err_q       <= 1'b0;
      key_q[0]    <= '0;
      key_q[1]    <= '0;
      key_vld_q   <= 2'b00;
      owner_q     <= 1'b0;
      owner_vld_q <= 1'b0;
      rr_ptr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      op_q        <= op_d;
      data_q      <= data_d;
      res_q       <= res_d;
      err_q       <= err_d;
      key_q[0]    <= key_d[0];
      key_q[1]    <= key_d[1];
      key_vld_q   <= key_vld_d;
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_aes_core_sched.sv
// -----------------------------------------------------------------------------
// tb_aes_core_sched
// Self-checking bench for aes_core_sched. A behavioural AES stand-in answers
// key loads and block ops with configurable latency; a directed table, a few
// hand-written multi-cycle sequences and a randomized run against a reference
// model check responses, key reloads and cycle timing.
// -----------------------------------------------------------------------------
module tb_aes_core_sched;

  localparam logic [1:0] OP_KEY = 2'b00;
  localparam logic [1:0] OP_ENC = 2'b01;
  localparam logic [1:0] OP_DEC = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  logic          clk = 1'b0;
  logic          resetL = 1'b0;
  logic [1:0]    req_valid = 2'b00;
  logic [1:0]    req_ready;
  logic [3:0]    req_op = 4'h0;
  logic [511:0]  req_key = '0;
  logic [255:0]  req_data = '0;
  logic [1:0]    resp_valid;
  logic          resp_err;
  logic [127:0]  resp_data;
  logic          core_key_load;
  logic [255:0]  core_key;
  logic          core_key_ready = 1'b0;
  logic          core_start;
  logic          core_decrypt;
  logic [127:0]  core_din;
  logic          core_done = 1'b0;
  logic [127:0]  core_dout = '0;

  aes_core_sched #(.KEY_W(256), .DATA_W(128)) dut (
    .clk(clk), .resetL(resetL),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_key(req_key), .req_data(req_data),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_data(resp_data),
    .core_key_load(core_key_load), .core_key(core_key), .core_key_ready(core_key_ready),
    .core_start(core_start), .core_decrypt(core_decrypt), .core_din(core_din),
    .core_done(core_done), .core_dout(core_dout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Stand-in for the AES datapath: any key-dependent bijection will do.
  function automatic logic [127:0] fake(input logic [127:0] d, input logic dec, input logic [255:0] k);
    return {d[62:0], d[127:63]} ^ k[255:128] ^ (k[127:0] + (dec ? 128'd1 : 128'd2));
  endfunction

  // ---------------- core model + event monitor (negedge) ----------------
  int           kdelay = 3;
  int           ddelay = 14;
  int           kcnt = 0, dcnt = 0;
  logic [255:0] key_lat = '0;
  logic [127:0] din_lat = '0;
  logic         dec_lat = 1'b0;
  int           kl_cnt = 0, kl_cyc = 0, kr_cyc = 0;
  logic [255:0] kl_key = '0;
  int           st_cnt = 0, st_cyc = 0, done_cyc = 0;
  logic         st_dec = 1'b0;
  logic [127:0] st_din = '0;
  int           resp_cnt = 0, last_rcyc = 0;
  logic [1:0]   last_rv = 2'b00;
  logic         last_err = 1'b0;
  logic [127:0] last_data = '0;

  always @(negedge clk) begin
    if (resp_valid != 2'b00) begin
      resp_cnt  <= resp_cnt + 1;
      last_rv   <= resp_valid;
      last_err  <= resp_err;
      last_data <= resp_data;
      last_rcyc <= cyc;
    end
    if (core_key_load) begin
      kl_cnt         <= kl_cnt + 1;
      kl_cyc         <= cyc;
      kl_key         <= core_key;
      key_lat        <= core_key;
      core_key_ready <= 1'b0;
      kcnt           <= kdelay;
    end else if (kcnt == 1) begin
      kcnt           <= 0;
      core_key_ready <= 1'b1;
      kr_cyc         <= cyc;
    end else if (kcnt > 1) begin
      kcnt <= kcnt - 1;
    end
    if (core_start) begin
      st_cnt    <= st_cnt + 1;
      st_cyc    <= cyc;
      st_dec    <= core_decrypt;
      st_din    <= core_din;
      din_lat   <= core_din;
      dec_lat   <= core_decrypt;
      dcnt      <= ddelay;
      core_done <= 1'b0;
    end else if (dcnt == 1) begin
      dcnt      <= 0;
      core_done <= 1'b1;
      core_dout <= fake(din_lat, dec_lat, key_lat);
      done_cyc  <= cyc;
    end else begin
      core_done <= 1'b0;
      if (dcnt > 1) dcnt <= dcnt - 1;
    end
  end

  // ---------------- reference model ----------------
  logic [255:0] mkey [2];
  logic [1:0]   mkv;
  int           loaded_by;

  task automatic model_reset();
    mkey[0] = '0; mkey[1] = '0; mkv = 2'b00; loaded_by = -1;
  endtask

  task automatic model_step(input int id, input logic [1:0] op, input logic [255:0] key,
                            input logic [127:0] data, output logic err, output logic [127:0] d,
                            output int reload, output logic [255:0] ek);
    err = 1'b0; d = '0; reload = 0; ek = '0;
    if (op == OP_KEY) begin
      mkey[id] = key;
      mkv[id]  = 1'b1;
      if (loaded_by == id) loaded_by = -1;
    end else if (op == OP_RSV || !mkv[id]) begin
      err = 1'b1;
    end else begin
      reload    = (loaded_by != id) ? 1 : 0;
      ek        = mkey[id];
      loaded_by = id;
      d         = fake(data, op == OP_DEC, mkey[id]);
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "/core_key"}, core_key, '0);
    chk({tag, "/core_din"}, {128'd0, core_din}, '0);
    chk({tag, "/resp_data"}, {128'd0, resp_data}, '0);
    chk({tag, "/ctl"}, {248'd0, req_ready, resp_valid, resp_err, core_key_load, core_start, core_decrypt}, '0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    req_valid = 2'b01;
    resetL = 1'b0;
    #1;
    chk_zero_outs("reset");
    req_valid = 2'b00;
    repeat (2) @(negedge clk);
    resetL = 1'b1;
    model_reset();
  endtask

  task automatic send(input int id, input logic [1:0] op, input logic [255:0] key,
                      input logic [127:0] data, output int acc);
    acc = -1;
    @(negedge clk); #1;
    req_op[2*id +: 2]     = op;
    req_key[id*256 +: 256] = key;
    req_data[id*128 +: 128] = data;
    req_valid[id]         = 1'b1;
    for (int n = 0; n < 100; n++) begin
      #1;
      if (req_ready[id]) begin
        @(posedge clk); #1;
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    req_valid[id] = 1'b0;
    if (acc < 0) begin
      checks++; errors++;
      $display("FAIL accept: requester %0d not granted within 100 cycles", id);
    end
  endtask

  task automatic wait_resp(input int snap, output bit got);
    got = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk); #1;
      if (resp_cnt != snap) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_cmd(input string name, input int id, input logic [1:0] op,
                         input logic [255:0] key, input logic [127:0] data,
                         input logic exp_err, input logic [127:0] exp_data,
                         input int exp_reload, input logic [255:0] exp_key);
    int   acc, kl0, st0, rs0;
    bit   got;
    logic exp_start;
    exp_start = ((op == OP_ENC) || (op == OP_DEC)) && !exp_err;
    kl0 = kl_cnt; st0 = st_cnt; rs0 = resp_cnt;
    send(id, op, key, data, acc);
    if (acc < 0) return;
    wait_resp(rs0, got);
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s/timeout: no resp_valid within 300 cycles", name);
      return;
    end
    chk({name, "/resp_valid"}, {254'd0, last_rv}, (id == 1) ? 256'd2 : 256'd1);
    chk({name, "/resp_err"}, {255'd0, last_err}, {255'd0, exp_err});
    chk({name, "/resp_data"}, {128'd0, last_data}, {128'd0, exp_data});
    chk({name, "/key_loads"}, 256'(kl_cnt - kl0), 256'(exp_reload));
    chk({name, "/starts"}, 256'(st_cnt - st0), exp_start ? 256'd1 : 256'd0);
    if (exp_reload != 0) begin
      chk({name, "/core_key"}, kl_key, exp_key);
      chk({name, "/load_cycle"}, 256'(kl_cyc), 256'(acc));
      chk({name, "/start_after_ready"}, 256'(st_cyc), 256'(kr_cyc + 1));
    end else if (exp_start) begin
      chk({name, "/start_cycle"}, 256'(st_cyc), 256'(acc));
    end
    if (exp_start) begin
      chk({name, "/decrypt"}, {255'd0, st_dec}, {255'd0, (op == OP_DEC)});
      chk({name, "/din"}, {128'd0, st_din}, {128'd0, data});
      chk({name, "/resp_cycle"}, 256'(last_rcyc), 256'(done_cyc + 1));
    end else begin
      chk({name, "/resp_cycle"}, 256'(last_rcyc), 256'(acc));
    end
    @(negedge clk); #1;
    chk({name, "/one_pulse"}, 256'(resp_cnt - rs0), 256'd1);
    $display("txn %s id=%0d op=%0d err=%0b data=%h loads=%0d", name, id, op, last_err,
             last_data, kl_cnt - kl0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string        name;
    int           id;
    logic [1:0]   op;
    logic [255:0] key;
    logic [127:0] data;
    logic         exp_err;
    logic [127:0] exp_data;
    int           exp_reload;
    logic [255:0] exp_key;
  } vec_t;

  vec_t tv[$];

  task automatic add_vec(input string name, input int id, input logic [1:0] op,
                         input logic [255:0] key, input logic [127:0] data, input logic exp_err,
                         input logic [127:0] exp_data, input int exp_reload,
                         input logic [255:0] exp_key);
    vec_t v;
    v.name = name; v.id = id; v.op = op; v.key = key; v.data = data;
    v.exp_err = exp_err; v.exp_data = exp_data; v.exp_reload = exp_reload; v.exp_key = exp_key;
    tv.push_back(v);
  endtask

  initial begin
    logic [255:0] k0, k1, k0b;
    logic [127:0] d0, d1, d2;
    int           acc, kl0, rs0;
    bit           got;

    k0  = {8{32'hA5A5_0F0F}};
    k1  = {8{32'h1234_5678}};
    k0b = {8{32'hDEAD_BEEF}};
    d0  = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    d1  = 128'hCAFE_F00D_0123_4567_89AB_CDEF_FEED_FACE;
    d2  = 128'h5A5A_A5A5_3C3C_C3C3_0F0F_F0F0_1111_2222;

    add_vec("enc_nokey",  0, OP_ENC, '0,  d0, 1'b1, '0,                     0, '0);
    add_vec("key0",       0, OP_KEY, k0,  '0, 1'b0, '0,                     0, '0);
    add_vec("enc0_miss",  0, OP_ENC, '0,  d0, 1'b0, fake(d0, 1'b0, k0),     1, k0);
    add_vec("enc0_hit",   0, OP_ENC, '0,  d1, 1'b0, fake(d1, 1'b0, k0),     0, '0);
    add_vec("rekey0",     0, OP_KEY, k0b, '0, 1'b0, '0,                     0, '0);
    add_vec("enc0_new",   0, OP_ENC, '0,  d1, 1'b0, fake(d1, 1'b0, k0b),    1, k0b);
    add_vec("key1",       1, OP_KEY, k1,  '0, 1'b0, '0,                     0, '0);
    add_vec("enc0_keep",  0, OP_ENC, '0,  d2, 1'b0, fake(d2, 1'b0, k0b),    0, '0);
    add_vec("rsv1",       1, OP_RSV, '0,  d2, 1'b1, '0,                     0, '0);
    add_vec("dec1_miss",  1, OP_DEC, '0,  d2, 1'b0, fake(d2, 1'b1, k1),     1, k1);
    add_vec("dec1_hit",   1, OP_DEC, '0,  d0, 1'b0, fake(d0, 1'b1, k1),     0, '0);
    add_vec("dec0_swap",  0, OP_DEC, '0,  d2, 1'b0, fake(d2, 1'b1, k0b),    1, k0b);

    // Directed table
    kdelay = 3; ddelay = 14;
    reset_dut();
    foreach (tv[i]) begin
      run_cmd(tv[i].name, tv[i].id, tv[i].op, tv[i].key, tv[i].data, tv[i].exp_err,
              tv[i].exp_data, tv[i].exp_reload, tv[i].exp_key);
    end

    // Simultaneous requests: requester 0 first, then 1, each reloading the core
    kdelay = 2; ddelay = 5;
    reset_dut();
    run_cmd("arb/key0", 0, OP_KEY, k0, '0, 1'b0, '0, 0, '0);
    run_cmd("arb/key1", 1, OP_KEY, k1, '0, 1'b0, '0, 0, '0);
    kl0 = kl_cnt; rs0 = resp_cnt;
    @(negedge clk); #1;
    req_op = {OP_DEC, OP_DEC}; req_data = {d1, d2}; req_valid = 2'b11;
    #1;
    chk("arb/first_grant", {254'd0, req_ready}, 256'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_resp(rs0, got);
    chk("arb/resp0_seen", {255'd0, got}, 256'd1);
    chk("arb/resp0_valid", {254'd0, last_rv}, 256'd1);
    chk("arb/resp0_data", {128'd0, last_data}, {128'd0, fake(d2, 1'b1, k0)});
    chk("arb/no_ready_in_resp", {254'd0, req_ready}, 256'd0);
    rs0 = resp_cnt;
    acc = -1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk); #1;
      if (req_ready != 2'b00) begin
        chk("arb/second_grant", {254'd0, req_ready}, 256'd2);
        @(posedge clk); #1;
        acc = cyc;
        break;
      end
    end
    req_valid[1] = 1'b0;
    chk("arb/next_accept_cycle", 256'(acc), 256'(last_rcyc + 2));
    wait_resp(rs0, got);
    chk("arb/resp1_valid", {254'd0, last_rv}, 256'd2);
    chk("arb/resp1_data", {128'd0, last_data}, {128'd0, fake(d1, 1'b1, k1)});
    chk("arb/two_loads", 256'(kl_cnt - kl0), 256'd2);
    @(negedge clk); #1;
    req_op = {OP_ENC, OP_ENC}; req_valid = 2'b11;
    #1;
    chk("arb/rr_back_to_0", {254'd0, req_ready}, 256'd1);
    req_valid = 2'b00;
    $display("txn arb: both-valid sequence done");

    // Reset asserted while waiting for key expansion
    kdelay = 8; ddelay = 4;
    reset_dut();
    run_cmd("kw/key0", 0, OP_KEY, k0, '0, 1'b0, '0, 0, '0);
    rs0 = resp_cnt;
    send(0, OP_ENC, '0, d0, acc);
    @(negedge clk); #1;
    chk("kw/key_driven", core_key, k0);
    resetL = 1'b0;
    #1;
    chk_zero_outs("kw/reset");
    @(negedge clk);
    resetL = 1'b1;
    model_reset();
    repeat (20) @(negedge clk);
    #1;
    chk("kw/resp_dropped", 256'(resp_cnt - rs0), 256'd0);
    run_cmd("kw/enc_after", 0, OP_ENC, '0, d0, 1'b1, '0, 0, '0);

    // Randomized commands against the reference model
    reset_dut();
    for (int t = 0; t < 40; t++) begin
      int           id, r, reload;
      logic [1:0]   op;
      logic [255:0] key, ek;
      logic [127:0] data, ed;
      logic         ee;
      id   = $urandom_range(0, 1);
      r    = $urandom_range(0, 19);
      op   = (r < 5) ? OP_KEY : (r < 6) ? OP_RSV : (r < 13) ? OP_ENC : OP_DEC;
      key  = {8{$urandom()}};
      data = {$urandom(), $urandom(), $urandom(), $urandom()};
      kdelay = $urandom_range(1, 4);
      ddelay = $urandom_range(1, 16);
      model_step(id, op, key, data, ee, ed, reload, ek);
      run_cmd($sformatf("rnd%0d", t), id, op, key, data, ee, ed, reload, ek);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
